ahb_burst_master: RTL and testbench
===================================

Name: ahb_burst_master

Overview:
- Command-driven AHB-Lite master that generates the transfers consumed by the codebase's AHB-to-peripheral bridge.
- Accepts one burst command at a time and drives NONSEQ/SEQ/BUSY/IDLE address phases with correct INCR/WRAP addressing.
- Streams write data in and read data out, honours h_ready wait states, and aborts on a two-cycle ERROR response.
- Sits between a local controller (DMA/CPU stub) and the AHB slave port of the bridge.

Parameters:
- LEN_W, 8, width of cmd_len (INCR undefined-length beat count).

Ports:
- h_clk  in  1  bus clock.
- h_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; high only in S_IDLE.
- cmd_addr  in  32  start byte address.
- cmd_burst  in  3  AHB burst encoding.
- cmd_size  in  3  AHB size encoding.
- cmd_write  in  1  1 = write burst.
- cmd_len  in  LEN_W  beat count, used only for INCR (001); 0 is treated as 1.
- wd_valid  in  1  write-data stream valid.
- wd_ready  out  1  write-data stream accept.
- wd_data  in  32  write-data beat.
- wd_strb  in  4  write-data byte strobes.
- rd_valid  out  1  read beat valid (single-cycle pulse).
- rd_data  out  32  read data.
- rd_last  out  1  final read beat.
- done  out  1  single-cycle pulse at end of command.
- done_err  out  1  qualifies done; 1 = aborted or rejected.
- h_addr  out  32  AHB address.
- h_burst  out  3  AHB burst.
- h_size  out  3  AHB size.
- h_trans  out  2  AHB trans.
- h_write  out  1  AHB direction.
- h_wdata  out  32  AHB write data.
- h_wstrb  out  4  AHB write strobes.
- h_rdata  in  32  AHB read data.
- h_ready  in  1  AHB ready.
- h_resp  in  1  AHB response; 1 = ERROR.

Behaviour:
- Encodings:
  - trans: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - burst: SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- Reset values: all AHB outputs 0 (h_trans=IDLE); cmd_ready=1; wd_ready, rd_valid, rd_last, done, done_err all 0; FSM in S_IDLE.
- Reset mid-burst drops the command immediately; no done pulse is produced.
- Beat count:
  - SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16.
  - INCR=max(cmd_len,1).
- Command rejection:
  - Triggers on cmd_size>2, or on a start address not aligned to 1<<size.
  - The command is accepted, no bus activity occurs, and done=1, done_err=1 the next cycle.
- Address generation:
  - INCR types: next = addr + (1<<size).
  - WRAP types: bnd = beats<<size; next = (addr & ~(bnd-1)) | ((addr+(1<<size)) & (bnd-1)).
  - If an INCR/INCRx next address crosses a 1 KB boundary, that beat is issued as NONSEQ with h_burst=INCR.
- FSM states:
  - S_IDLE: on cmd_valid, latch the command and go to S_ADDR.
  - S_ADDR:
    - Drive NONSEQ for the first beat and SEQ after that.
    - A beat's address phase completes in the cycle h_ready=1; the next address is presented the following cycle.
    - For writes, each beat needs wd_valid:
      - Before the first beat, hold IDLE until wd_valid.
      - Mid-burst, drive BUSY at the held next address until wd_valid.
    - wd_ready is asserted in the cycle the beat's address phase completes (h_ready=1 and trans NONSEQ/SEQ).
    - The data is registered onto h_wdata/h_wstrb for the following data phase and held until that phase completes.
    - After the last address phase completes, go to S_LAST.
  - S_LAST: drive IDLE and wait for the final data phase (h_ready=1), then go to S_DONE.
  - S_DONE: pulse done for one cycle (done_err=0), return to S_IDLE, and reassert cmd_ready the next cycle.
  - S_ERR: entered on h_resp=1 with h_ready=0.
    - In that same cycle, drive h_trans=IDLE combinationally.
    - Wait for h_resp=1 with h_ready=1, then pulse done with done_err=1 and discard remaining beats.
- Read data: rd_valid=1 for each read data phase that completes with h_ready=1 and h_resp=0.
  - rd_data is registered from h_rdata (1-cycle latency).
  - rd_last marks the final beat.
- Write data flow: h_wdata is valid exactly in the data phase.
- Overlap: at most one data phase is outstanding; address phase N+1 overlaps data phase N.

Decomposition:
- ahb_pkg holds:
  - trans and burst localparams/enum;
  - the beats_of(burst,len) function;
  - the FSM state typedef.
- Sub-module ahb_next_addr: combinational INCR/WRAP/1 KB-crossing next-address and NONSEQ-restart flag.

Test Plan:
- INCR4 write, addr 0x100, size 2, wd always valid, h_ready=1 -> trans NONSEQ,SEQ,SEQ,SEQ; addr 0x100,0x104,0x108,0x10C; wdata aligned one cycle later; done after 5 address cycles, done_err=0.
- WRAP4 read, addr 0x38, size 2 -> addr 0x38,0x30,0x34,0x38? no: 0x38,0x3C,0x30,0x34; 4 rd_valid pulses, rd_last on the 4th.
- INCR write, cmd_len=3, addr 0x3FC, size 2 -> beats at 0x3FC (NONSEQ), 0x400 (NONSEQ, 1 KB restart), 0x404 (SEQ).
- INCR8 write with wd_valid low for 2 cycles after beat 2 -> two BUSY cycles at the held beat-3 address, then SEQ resumes; h_ready low for 3 cycles on beat 5 -> address and wdata held stable.
- INCR4 read, ERROR on beat 2 (h_resp=1 with h_ready=0, then h_resp=1 with h_ready=1) -> h_trans=IDLE in the first error cycle, no further beats, done_err=1, only 1 rd_valid.
- cmd_size=3 or addr 0x102 with size 2 -> no non-IDLE h_trans; done with done_err=1 the cycle after accept.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, burst helpers and FSM state type for the burst master.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } burst_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_DONE,
        S_ERR
    } state_e;

    // Beat counter width; cmd_len wider than this is truncated.
    localparam int unsigned CNT_W = 16;

    // Lowest address bit above the 1 KB boundary an AHB burst may not cross.
    localparam int unsigned KB_BIT = 10;

    // Number of beats in a burst; undefined-length INCR uses len, with 0 treated as 1.
    function automatic logic [CNT_W-1:0] beats_of(input logic [2:0] burst,
                                                  input logic [CNT_W-1:0] len);
        case (burst)
            BURST_SINGLE:              beats_of = CNT_W'(1);
            BURST_INCR:                beats_of = (len == '0) ? CNT_W'(1) : len;
            BURST_WRAP4, BURST_INCR4:  beats_of = CNT_W'(4);
            BURST_WRAP8, BURST_INCR8:  beats_of = CNT_W'(8);
            default:                   beats_of = CNT_W'(16);
        endcase
    endfunction

    // True for the wrapping burst encodings.
    function automatic logic is_wrap(input logic [2:0] burst);
        return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_next_addr.sv
// Combinational next-beat address for INCR/WRAP bursts, plus the flag that forces
// a NONSEQ restart when an incrementing burst would cross a 1 KB boundary.
module ahb_next_addr
    import ahb_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    input  logic [2:0]  i_burst,
    output logic [31:0] o_next_addr,
    output logic        o_restart
);

    logic [31:0] w_incr;
    logic [31:0] w_sum;
    logic [31:0] w_mask;

    assign w_incr = 32'd1 << i_size;
    assign w_sum  = i_addr + w_incr;

    // Wrap bursts keep the upper bits and wrap the low bits inside the burst window;
    // incrementing bursts flag a restart when the 1 KB page changes.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_mask      = '0;
        o_next_addr = w_sum;
        o_restart   = 1'b0;
        if (is_wrap(i_burst)) begin
            w_mask      = (32'(beats_of(i_burst, CNT_W'(1))) << i_size) - 32'd1;
            o_next_addr = (i_addr & ~w_mask) | (w_sum & w_mask);
        end else if (i_burst != BURST_SINGLE) begin
            o_restart = (w_sum[31:KB_BIT] != i_addr[31:KB_BIT]);
        end
    end

endmodule

// File: rtl/ahb_burst_master.sv
// Command-driven AHB-Lite burst master: one command at a time, pipelined address and
// data phases, write-data and read-data streams, ERROR abort and illegal-command reject.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             h_clk,
    input  logic             h_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [2:0]       cmd_burst,
    input  logic [2:0]       cmd_size,
    input  logic             cmd_write,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [31:0]      wd_data,
    input  logic [3:0]       wd_strb,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             rd_last,
    output logic             done,
    output logic             done_err,
    output logic [31:0]      h_addr,
    output logic [2:0]       h_burst,
    output logic [2:0]       h_size,
    output logic [1:0]       h_trans,
    output logic             h_write,
    output logic [31:0]      h_wdata,
    output logic [3:0]       h_wstrb,
    input  logic [31:0]      h_rdata,
    input  logic             h_ready,
    input  logic             h_resp
);

    state_e           r_state;
    state_e           w_next_state;

    logic [31:0]      r_addr;
    logic [2:0]       r_size;
    logic [2:0]       r_burst;
    logic             r_write;
    logic             r_nonseq;      // current beat starts a (re)started burst
    logic             r_restarted;   // a 1 KB restart happened; remaining beats are INCR
    logic [CNT_W-1:0] r_beats_left;
    logic             r_err;

    logic             r_dp_valid;    // a data phase is outstanding on the bus
    logic             r_dp_last;
    logic             r_dp_write;

    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_rd_valid;
    logic [31:0]      r_rd_data;
    logic             r_rd_last;

    trans_e           w_trans;
    logic             w_addr_done;
    logic             w_err_wait;
    logic             w_reject;
    logic             w_rd_beat;
    logic             w_last_beat;
    logic [31:0]      w_next_addr;
    logic             w_restart;

    ahb_next_addr u_next_addr (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_restart   (w_restart)
    );

    assign w_reject    = (cmd_size > 3'd2) ||
                         ((cmd_addr & ((32'd1 << cmd_size) - 32'd1)) != 32'd0);
    assign w_err_wait  = r_dp_valid && h_resp && !h_ready;
    assign w_last_beat = (r_beats_left == CNT_W'(1));
    assign w_addr_done = h_ready && ((w_trans == TRANS_NONSEQ) || (w_trans == TRANS_SEQ));
    assign w_rd_beat   = r_dp_valid && !r_dp_write && h_ready && !h_resp;

    assign wd_ready = w_addr_done && r_write;
    assign h_trans  = w_trans;
    assign h_addr   = r_addr;
    assign h_burst  = r_restarted ? BURST_INCR : r_burst;
    assign h_size   = r_size;
    assign h_write  = r_write;
    assign h_wdata  = r_wdata;
    assign h_wstrb  = r_wstrb;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;

    // State register.
    always_ff @(posedge h_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (h_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the combinational bus/handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_trans      = TRANS_IDLE;
        cmd_ready    = 1'b0;
        done         = 1'b0;
        done_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = w_reject ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_err_wait) begin
                    // First ERROR cycle: withdraw the pending address phase at once.
                    w_next_state = S_ERR;
                end else if (r_write && !wd_valid) begin
                    // No data yet: IDLE before a (re)start beat, BUSY inside a burst.
                    w_trans = r_nonseq ? TRANS_IDLE : TRANS_BUSY;
                end else begin
                    w_trans = r_nonseq ? TRANS_NONSEQ : TRANS_SEQ;
                    if (h_ready && w_last_beat) begin
                        w_next_state = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (w_err_wait) begin
                    w_next_state = S_ERR;
                end else if (h_ready) begin
                    w_next_state = S_DONE;
                end
            end
            S_ERR: begin
                if (h_resp && h_ready) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                done_err     = r_err;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Command latch, beat sequencing, data-phase tracking and data stream registers.
    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            r_addr       <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_write      <= 1'b0;
            r_nonseq     <= 1'b0;
            r_restarted  <= 1'b0;
            r_beats_left <= '0;
            r_err        <= 1'b0;
            r_dp_valid   <= 1'b0;
            r_dp_last    <= 1'b0;
            r_dp_write   <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_last    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_err <= w_reject;
                if (!w_reject) begin
                    r_addr       <= cmd_addr;
                    r_size       <= cmd_size;
                    r_burst      <= cmd_burst;
                    r_write      <= cmd_write;
                    r_nonseq     <= 1'b1;
                    r_restarted  <= 1'b0;
                    r_beats_left <= beats_of(cmd_burst, CNT_W'(cmd_len));
                end
            end

            if (r_state == S_ERR) begin
                r_err <= 1'b1;
            end

            // Advance to the next beat once its address phase is accepted;
            // the final beat's address is simply held.
            if (w_addr_done) begin
                r_beats_left <= r_beats_left - CNT_W'(1);
                r_nonseq     <= w_restart;
                if (w_restart) begin
                    r_restarted <= 1'b1;
                end
                if (!w_last_beat) begin
                    r_addr <= w_next_addr;
                end
            end

            // The accepted address phase becomes the single outstanding data phase.
            if (w_addr_done) begin
                r_dp_valid <= 1'b1;
                r_dp_last  <= w_last_beat;
                r_dp_write <= r_write;
            end else if (h_ready) begin
                r_dp_valid <= 1'b0;
            end

            // Write data moves onto the bus for the data phase that follows acceptance.
            if (wd_ready) begin
                r_wdata <= wd_data;
                r_wstrb <= wd_strb;
            end

            r_rd_valid <= w_rd_beat;
            r_rd_last  <= w_rd_beat && r_dp_last;
            if (w_rd_beat) begin
                r_rd_data <= h_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed self-checking bench for ahb_burst_master; the bench plays the AHB slave.
module tb_ahb_burst_master;
    import ahb_pkg::*;

    localparam int LEN_W = 8;

    logic             h_clk = 1'b0;
    logic             h_reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_addr = '0;
    logic [2:0]       cmd_burst = '0;
    logic [2:0]       cmd_size = '0;
    logic             cmd_write = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             wd_valid = 1'b0;
    logic             wd_ready;
    logic [31:0]      wd_data = '0;
    logic [3:0]       wd_strb = 4'hF;
    logic             rd_valid;
    logic [31:0]      rd_data;
    logic             rd_last;
    logic             done;
    logic             done_err;
    logic [31:0]      h_addr;
    logic [2:0]       h_burst;
    logic [2:0]       h_size;
    logic [1:0]       h_trans;
    logic             h_write;
    logic [31:0]      h_wdata;
    logic [3:0]       h_wstrb;
    logic [31:0]      h_rdata = '0;
    logic             h_ready = 1'b1;
    logic             h_resp = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // One row per cycle of the stalled INCR8 write.
    typedef struct {
        logic        rdy;
        logic        wv;
        logic [3:0]  wd;
        logic [1:0]  tr;
        logic [31:0] ad;
        logic        ckw;
        logic [3:0]  wdx;
    } vec_t;

    vec_t t4 [14] = '{
        '{1'b1, 1'b1, 4'd0, TRANS_NONSEQ, 32'h200, 1'b0, 4'd0},
        '{1'b1, 1'b1, 4'd1, TRANS_SEQ,    32'h204, 1'b1, 4'd0},
        '{1'b1, 1'b0, 4'd2, TRANS_BUSY,   32'h208, 1'b1, 4'd1},
        '{1'b1, 1'b0, 4'd2, TRANS_BUSY,   32'h208, 1'b1, 4'd1},
        '{1'b1, 1'b1, 4'd2, TRANS_SEQ,    32'h208, 1'b1, 4'd1},
        '{1'b1, 1'b1, 4'd3, TRANS_SEQ,    32'h20C, 1'b1, 4'd2},
        '{1'b0, 1'b1, 4'd4, TRANS_SEQ,    32'h210, 1'b1, 4'd3},
        '{1'b0, 1'b1, 4'd4, TRANS_SEQ,    32'h210, 1'b1, 4'd3},
        '{1'b0, 1'b1, 4'd4, TRANS_SEQ,    32'h210, 1'b1, 4'd3},
        '{1'b1, 1'b1, 4'd4, TRANS_SEQ,    32'h210, 1'b1, 4'd3},
        '{1'b1, 1'b1, 4'd5, TRANS_SEQ,    32'h214, 1'b1, 4'd4},
        '{1'b1, 1'b1, 4'd6, TRANS_SEQ,    32'h218, 1'b1, 4'd5},
        '{1'b1, 1'b1, 4'd7, TRANS_SEQ,    32'h21C, 1'b1, 4'd6},
        '{1'b1, 1'b0, 4'd0, TRANS_IDLE,   32'h21C, 1'b1, 4'd7}
    };

    logic [31:0] wrap_addr [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};

    ahb_burst_master #(.LEN_W(LEN_W)) dut (
        .h_clk     (h_clk),
        .h_reset   (h_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_size  (cmd_size),
        .cmd_write (cmd_write),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .done_err  (done_err),
        .h_addr    (h_addr),
        .h_burst   (h_burst),
        .h_size    (h_size),
        .h_trans   (h_trans),
        .h_write   (h_write),
        .h_wdata   (h_wdata),
        .h_wstrb   (h_wstrb),
        .h_rdata   (h_rdata),
        .h_ready   (h_ready),
        .h_resp    (h_resp)
    );

    always #5 h_clk = ~h_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; outputs are sampled 2 time units after the edge.
    task automatic issue(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                         input logic w, input logic [LEN_W-1:0] l);
        @(posedge h_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_burst = b;
        cmd_size  = s;
        cmd_write = w;
        cmd_len   = l;
        #1;
        check("cmd_ready at accept", cmd_ready, 1);
    endtask

    // One bus cycle of slave response and write-stream stimulus.
    task automatic step(input logic rdy, input logic resp, input logic wv,
                        input logic [31:0] wd, input logic [31:0] rd);
        @(posedge h_clk);
        #1;
        cmd_valid = 1'b0;
        h_ready   = rdy;
        h_resp    = resp;
        wd_valid  = wv;
        wd_data   = wd;
        h_rdata   = rd;
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge h_clk);
        #1;
        h_reset = 1'b0;
        #1;
        check("rst cmd_ready", cmd_ready, 1);
        check("rst h_trans", h_trans, TRANS_IDLE);
        check("rst h_addr", h_addr, 0);
        check("rst h_wdata", h_wdata, 0);
        check("rst wd_ready", wd_ready, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst done", done, 0);
        check("rst done_err", done_err, 0);

        // INCR4 write at 0x100, data always available, no wait states
        issue(32'h100, BURST_INCR4, 3'd2, 1'b1, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'hA000_0000 + i, '0);
            check("t1 trans", h_trans, (i == 0) ? TRANS_NONSEQ : TRANS_SEQ);
            check("t1 addr", h_addr, 32'h100 + 4 * i);
            check("t1 wd_ready", wd_ready, 1);
            check("t1 burst", h_burst, BURST_INCR4);
            check("t1 write", h_write, 1);
            if (i > 0) check("t1 wdata", h_wdata, 32'hA000_0000 + i - 1);
        end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t1 last trans", h_trans, TRANS_IDLE);
        check("t1 last wdata", h_wdata, 32'hA000_0003);
        check("t1 last wstrb", h_wstrb, 4'hF);
        check("t1 last wd_ready", wd_ready, 0);
        check("t1 early done", done, 0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t1 done", done, 1);
        check("t1 done_err", done_err, 0);
        check("t1 cmd_ready in done", cmd_ready, 0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t1 cmd_ready after", cmd_ready, 1);
        check("t1 done after", done, 0);

        // WRAP4 read at 0x38
        issue(32'h38, BURST_WRAP4, 3'd2, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t2 trans first", h_trans, TRANS_NONSEQ);
        check("t2 addr first", h_addr, 32'h38);
        check("t2 rd_valid first", rd_valid, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 32'hB000_0000 + i - 1);
            if (i <= 3) begin
                check("t2 trans", h_trans, TRANS_SEQ);
                check("t2 addr", h_addr, wrap_addr[i]);
            end else begin
                check("t2 trans tail", h_trans, TRANS_IDLE);
            end
            check("t2 rd_valid", rd_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                check("t2 rd_data", rd_data, 32'hB000_0000 + i - 2);
                check("t2 rd_last", rd_last, (i == 5) ? 1 : 0);
            end
            check("t2 done", done, (i == 5) ? 1 : 0);
        end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t2 rd_valid after", rd_valid, 0);

        // Undefined-length INCR write crossing the 1 KB boundary
        issue(32'h3FC, BURST_INCR, 3'd2, 1'b1, 8'd3);
        step(1'b1, 1'b0, 1'b1, 32'hC000_0000, '0);
        check("t3 trans b0", h_trans, TRANS_NONSEQ);
        check("t3 addr b0", h_addr, 32'h3FC);
        step(1'b1, 1'b0, 1'b1, 32'hC000_0001, '0);
        check("t3 trans b1", h_trans, TRANS_NONSEQ);
        check("t3 addr b1", h_addr, 32'h400);
        check("t3 burst b1", h_burst, BURST_INCR);
        check("t3 wdata b0", h_wdata, 32'hC000_0000);
        step(1'b1, 1'b0, 1'b1, 32'hC000_0002, '0);
        check("t3 trans b2", h_trans, TRANS_SEQ);
        check("t3 addr b2", h_addr, 32'h404);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t3 trans tail", h_trans, TRANS_IDLE);
        check("t3 wdata b2", h_wdata, 32'hC000_0002);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t3 done", done, 1);
        check("t3 done_err", done_err, 0);

        // INCR4 read crossing 1 KB: the restart beat and the rest switch to INCR
        issue(32'h3F8, BURST_INCR4, 3'd2, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t3b trans b1", h_trans, TRANS_SEQ);
        check("t3b burst b1", h_burst, BURST_INCR4);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t3b trans b2", h_trans, TRANS_NONSEQ);
        check("t3b addr b2", h_addr, 32'h400);
        check("t3b burst b2", h_burst, BURST_INCR);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t3b trans b3", h_trans, TRANS_SEQ);
        check("t3b burst b3", h_burst, BURST_INCR);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t3b done", done, 1);

        // INCR8 write with a write-data gap (BUSY) and a 3-cycle wait state
        issue(32'h200, BURST_INCR8, 3'd2, 1'b1, '0);
        for (int i = 0; i < 14; i++) begin
            step(t4[i].rdy, 1'b0, t4[i].wv, 32'hD000_0000 + 32'(t4[i].wd), '0);
            check("t4 trans", h_trans, t4[i].tr);
            if (t4[i].tr != TRANS_IDLE) check("t4 addr", h_addr, t4[i].ad);
            check("t4 wd_ready", wd_ready, (t4[i].rdy && t4[i].tr[1]) ? 1 : 0);
            if (t4[i].ckw) check("t4 wdata", h_wdata, 32'hD000_0000 + 32'(t4[i].wdx));
        end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t4 done", done, 1);
        check("t4 done_err", done_err, 0);

        // INCR4 read with a two-cycle ERROR response on the second beat
        issue(32'h40, BURST_INCR4, 3'd2, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t5 trans b0", h_trans, TRANS_NONSEQ);
        step(1'b1, 1'b0, 1'b0, '0, 32'hE000_0000);
        check("t5 trans b1", h_trans, TRANS_SEQ);
        check("t5 addr b1", h_addr, 32'h44);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        check("t5 trans err1", h_trans, TRANS_IDLE);
        check("t5 rd_valid b0", rd_valid, 1);
        check("t5 rd_data b0", rd_data, 32'hE000_0000);
        check("t5 rd_last b0", rd_last, 0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        check("t5 trans err2", h_trans, TRANS_IDLE);
        check("t5 rd_valid err2", rd_valid, 0);
        check("t5 done early", done, 0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t5 done", done, 1);
        check("t5 done_err", done_err, 1);
        check("t5 rd_valid end", rd_valid, 0);
        check("t5 trans end", h_trans, TRANS_IDLE);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t5 cmd_ready", cmd_ready, 1);
        check("t5 trans idle", h_trans, TRANS_IDLE);

        // Rejected commands: illegal size, then misaligned address
        issue(32'h100, BURST_INCR4, 3'd3, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t6a done", done, 1);
        check("t6a done_err", done_err, 1);
        check("t6a trans", h_trans, TRANS_IDLE);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t6a cmd_ready", cmd_ready, 1);
        check("t6a done after", done, 0);
        issue(32'h102, BURST_INCR4, 3'd2, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, 32'hF000_0000, '0);
        check("t6b done", done, 1);
        check("t6b done_err", done_err, 1);
        check("t6b trans", h_trans, TRANS_IDLE);
        check("t6b wd_ready", wd_ready, 0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t6b cmd_ready", cmd_ready, 1);

        // Reset in the middle of a read burst drops it without a done pulse
        issue(32'h80, BURST_INCR4, 3'd2, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 32'h1234_5678);
        check("t7 trans b1", h_trans, TRANS_SEQ);
        @(posedge h_clk);
        #1;
        h_reset = 1'b1;
        #1;
        @(posedge h_clk);
        #1;
        h_reset = 1'b0;
        #1;
        check("t7 trans", h_trans, TRANS_IDLE);
        check("t7 addr", h_addr, 0);
        check("t7 cmd_ready", cmd_ready, 1);
        check("t7 rd_valid", rd_valid, 0);
        check("t7 done", done, 0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t7 done later", done, 0);
        check("t7 trans later", h_trans, TRANS_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
